// File: rtl/tile_buffer_bank.sv
// tile_buffer_bank: multi-buffer tile scratchpad with per-buffer tile length, streaming read gating and reread wrap.
// Optional macro TILE_BUFFER_ERR_EN adds err_sticky / err_clear for illegal (not-ready) requests.

module tile_buffer_ctrl #(
  parameter int TILE_COUNT = 32,
  parameter int LW         = 6,
  parameter int TW         = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_hit,
  input  logic [LW-1:0] cfg_len,
  input  logic          clr_hit,
  input  logic          wr_req,
  input  logic          rd_req,
  output logic          wr_ok,
  output logic          rd_ok,
  output logic          wr_fire,
  output logic          rd_fire,
  output logic          wr_last,
  output logic          rd_last,
  output logic [TW-1:0] wr_ptr,
  output logic [TW-1:0] rd_ptr,
  output logic [LW-1:0] wr_cnt,
  output logic [LW-1:0] len
);
  logic [LW-1:0] len_q, wr_cnt_q, len_n, wr_cnt_c;
  logic [TW-1:0] rd_idx_q;

  // Clear/cfg take effect before this cycle's write/read are evaluated.
  assign len_n    = cfg_hit ? cfg_len : len_q;
  assign wr_cnt_c = clr_hit ? '0 : wr_cnt_q;
  assign wr_ok    = wr_cnt_c < len_n;
  assign rd_ok    = !clr_hit && (LW'(rd_idx_q) < wr_cnt_q);
  assign wr_fire  = wr_req && wr_ok;
  assign rd_fire  = rd_req && rd_ok;
  assign wr_last  = (wr_cnt_c + LW'(1)) == len_n;
  assign rd_last  = LW'(rd_idx_q) == (len_q - LW'(1));
  assign wr_ptr   = wr_cnt_c[TW-1:0];
  assign rd_ptr   = rd_idx_q;
  assign wr_cnt   = wr_cnt_q;
  assign len      = len_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q    <= LW'(TILE_COUNT);
      wr_cnt_q <= '0;
      rd_idx_q <= '0;
    end else begin
      len_q    <= len_n;
      wr_cnt_q <= wr_fire ? wr_cnt_c + LW'(1) : wr_cnt_c;
      if (clr_hit)      rd_idx_q <= '0;
      else if (rd_fire) rd_idx_q <= rd_last ? '0 : rd_idx_q + TW'(1);
    end
  end
endmodule

module tile_buffer_bank #(
  parameter int  DATA_WIDTH   = 8,
  parameter int  TILE_ELEMS   = 32,
  parameter int  BUFFER_WIDTH = 8192,
  parameter int  BUFFER_COUNT = 4,
  localparam int TILE_WIDTH   = TILE_ELEMS * DATA_WIDTH,
  localparam int TILE_COUNT   = BUFFER_WIDTH / TILE_WIDTH,
  localparam int BW           = (BUFFER_COUNT > 1) ? $clog2(BUFFER_COUNT) : 1,
  localparam int TW           = (TILE_COUNT > 1) ? $clog2(TILE_COUNT) : 1,
  localparam int LW           = $clog2(TILE_COUNT + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [BW-1:0]         cfg_buffer,
  input  logic [LW-1:0]         cfg_len,
  input  logic                  write_valid,
  output logic                  write_ready,
  input  logic [BW-1:0]         write_buffer,
  input  logic [TILE_WIDTH-1:0] write_data,
  input  logic                  read_enable,
  output logic                  read_ready,
  input  logic [BW-1:0]         read_buffer,
  output logic [DATA_WIDTH-1:0] read_data [TILE_ELEMS],
  output logic                  read_valid,
  output logic                  writing_done,
  output logic                  reading_done,
  input  logic                  clear_enable,
  input  logic [BW-1:0]         clear_buffer,
  output logic [BUFFER_COUNT-1:0] buf_full,
`ifdef TILE_BUFFER_ERR_EN
  output logic                  err_sticky,
  input  logic                  err_clear,
`endif
  output logic [TW-1:0]         debug_w_tile_index
);
  localparam int AW = BW + TW;

  logic [BUFFER_COUNT-1:0] cfg_hit, clr_hit, wr_req, rd_req;
  logic [BUFFER_COUNT-1:0] wr_ok, rd_ok, wr_fire, rd_fire, wr_last, rd_last;
  logic [BUFFER_COUNT-1:0][TW-1:0] wr_ptr, rd_ptr;
  logic [BUFFER_COUNT-1:0][LW-1:0] wr_cnt, len;
  logic [LW-1:0] cfg_len_n;
  logic [TW-1:0] wr_idx, rd_idx;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [TILE_WIDTH-1:0] rd_q;
  logic [TILE_WIDTH-1:0] mem [2**AW];

  // Zero or out-of-range length means a full buffer.
  assign cfg_len_n = (cfg_len == '0 || cfg_len > LW'(TILE_COUNT)) ? LW'(TILE_COUNT) : cfg_len;

  for (genvar b = 0; b < BUFFER_COUNT; b++) begin : g_buf
    assign cfg_hit[b]  = cfg_we && (cfg_buffer == BW'(b));
    assign clr_hit[b]  = cfg_hit[b] || (clear_enable && (clear_buffer == BW'(b)));
    assign wr_req[b]   = write_valid && (write_buffer == BW'(b));
    assign rd_req[b]   = read_enable && (read_buffer == BW'(b));
    assign buf_full[b] = wr_cnt[b] == len[b];

    tile_buffer_ctrl #(.TILE_COUNT(TILE_COUNT), .LW(LW), .TW(TW)) u_ctrl (
      .clk     (clk),
      .reset   (reset),
      .cfg_hit (cfg_hit[b]),
      .cfg_len (cfg_len_n),
      .clr_hit (clr_hit[b]),
      .wr_req  (wr_req[b]),
      .rd_req  (rd_req[b]),
      .wr_ok   (wr_ok[b]),
      .rd_ok   (rd_ok[b]),
      .wr_fire (wr_fire[b]),
      .rd_fire (rd_fire[b]),
      .wr_last (wr_last[b]),
      .rd_last (rd_last[b]),
      .wr_ptr  (wr_ptr[b]),
      .rd_ptr  (rd_ptr[b]),
      .wr_cnt  (wr_cnt[b]),
      .len     (len[b])
    );
  end

  always_comb begin
    write_ready = 1'b0;
    read_ready  = 1'b0;
    wr_idx      = '0;
    rd_idx      = '0;
    for (int b = 0; b < BUFFER_COUNT; b++) begin
      if (write_buffer == BW'(b)) begin
        write_ready = wr_ok[b];
        wr_idx      = wr_ptr[b];
      end
      if (read_buffer == BW'(b)) begin
        read_ready = rd_ok[b];
        rd_idx     = rd_ptr[b];
      end
    end
  end

  assign wr_addr            = {write_buffer, wr_idx};
  assign rd_addr            = {read_buffer, rd_idx};
  assign debug_w_tile_index = wr_cnt[0][TW-1:0];

  always_ff @(posedge clk) begin
    if (|wr_fire) mem[wr_addr] <= write_data;
  end

  // Read port output register; holds the last tile until the next accepted read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q         <= '0;
      read_valid   <= 1'b0;
      writing_done <= 1'b0;
      reading_done <= 1'b0;
    end else begin
      read_valid   <= |rd_fire;
      writing_done <= |(wr_fire & wr_last);
      reading_done <= |(rd_fire & rd_last);
      if (|rd_fire) rd_q <= mem[rd_addr];
    end
  end

  for (genvar j = 0; j < TILE_ELEMS; j++) begin : g_elem
    assign read_data[j] = rd_q[j*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef TILE_BUFFER_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_sticky <= 1'b0;
    else if ((write_valid && !write_ready) || (read_enable && !read_ready)) err_sticky <= 1'b1;
    else if (err_clear) err_sticky <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_tile_buffer_bank.sv
// Bench for tile_buffer_bank: array-based buffer model checked every cycle plus directed literal checks.
module tb_tile_buffer_bank;
  localparam int DW = 8, TE = 32, TWID = 256, NB = 4, TC = 32, BW = 2, TW = 5, LW = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cfg_we, write_valid, write_ready, read_enable, read_ready;
  logic read_valid, writing_done, reading_done, clear_enable;
  logic [BW-1:0] cfg_buffer, write_buffer, read_buffer, clear_buffer;
  logic [LW-1:0] cfg_len;
  logic [TWID-1:0] write_data;
  logic [DW-1:0] read_data [TE];
  logic [NB-1:0] buf_full;
  logic [TW-1:0] debug_w_tile_index;
`ifdef TILE_BUFFER_ERR_EN
  logic err_sticky, err_clear;
`endif

  int n_chk = 0, n_err = 0;

  tile_buffer_bank dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_buffer(cfg_buffer), .cfg_len(cfg_len),
    .write_valid(write_valid), .write_ready(write_ready), .write_buffer(write_buffer), .write_data(write_data),
    .read_enable(read_enable), .read_ready(read_ready), .read_buffer(read_buffer), .read_data(read_data),
    .read_valid(read_valid), .writing_done(writing_done), .reading_done(reading_done),
    .clear_enable(clear_enable), .clear_buffer(clear_buffer), .buf_full(buf_full),
`ifdef TILE_BUFFER_ERR_EN
    .err_sticky(err_sticky), .err_clear(err_clear),
`endif
    .debug_w_tile_index(debug_w_tile_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [TWID-1:0] act, input logic [TWID-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [TWID-1:0] rep(input logic [7:0] v);
    return {TE{v}};
  endfunction

  function automatic logic [TWID-1:0] rdpk();
    logic [TWID-1:0] p;
    for (int j = 0; j < TE; j++) p[j*DW +: DW] = read_data[j];
    return p;
  endfunction

  // Model: per-buffer length, write count, read index and stored tiles.
  int mlen[NB], mwr[NB], mrd[NB], nlen[NB], wr0[NB], rd0[NB];
  bit clr[NB];
  logic [TWID-1:0] store [NB][TC];
  logic [TWID-1:0] e_data;
  logic [NB-1:0] e_full;
  logic e_rv, e_wd, e_rd, e_err, wok, rok;
  int wb, rb;

  always @(negedge clk) begin
    if (reset) begin
      for (int b = 0; b < NB; b++) begin mlen[b] = TC; mwr[b] = 0; mrd[b] = 0; end
      e_data = '0; e_rv = 0; e_wd = 0; e_rd = 0; e_err = 0;
      chk("rst_read_valid", read_valid, 0);
      chk("rst_writing_done", writing_done, 0);
      chk("rst_reading_done", reading_done, 0);
      chk("rst_read_data", rdpk(), 0);
      chk("rst_buf_full", buf_full, 0);
`ifdef TILE_BUFFER_ERR_EN
      chk("rst_err", err_sticky, 0);
`endif
    end else begin
      chk("read_valid", read_valid, e_rv);
      chk("writing_done", writing_done, e_wd);
      chk("reading_done", reading_done, e_rd);
      chk("read_data", rdpk(), e_data);
      for (int b = 0; b < NB; b++) e_full[b] = (mwr[b] == mlen[b]);
      chk("buf_full", buf_full, e_full);
      chk("debug_idx", debug_w_tile_index, mwr[0] % TC);
`ifdef TILE_BUFFER_ERR_EN
      chk("err_sticky", err_sticky, e_err);
`endif
      for (int b = 0; b < NB; b++) begin
        clr[b]  = (clear_enable && clear_buffer == b) || (cfg_we && cfg_buffer == b);
        nlen[b] = (cfg_we && cfg_buffer == b) ? ((cfg_len == 0 || cfg_len > TC) ? TC : int'(cfg_len)) : mlen[b];
        wr0[b]  = clr[b] ? 0 : mwr[b];
        rd0[b]  = clr[b] ? 0 : mrd[b];
      end
      wb = int'(write_buffer);
      rb = int'(read_buffer);
      wok = wr0[wb] < nlen[wb];
      rok = !clr[rb] && (mrd[rb] < mwr[rb]);
      chk("write_ready", write_ready, wok);
      chk("read_ready", read_ready, rok);
      e_wd = 0; e_rd = 0; e_rv = 0;
`ifdef TILE_BUFFER_ERR_EN
      if ((write_valid && !wok) || (read_enable && !rok)) e_err = 1;
      else if (err_clear) e_err = 0;
`endif
      if (write_valid && wok) begin
        store[wb][wr0[wb]] = write_data;
        wr0[wb]++;
        e_wd = (wr0[wb] == nlen[wb]);
      end
      if (read_enable && rok) begin
        e_rv = 1;
        e_data = store[rb][mrd[rb]];
        if (mrd[rb] == mlen[rb] - 1) begin rd0[rb] = 0; e_rd = 1; end
        else rd0[rb] = mrd[rb] + 1;
      end
      for (int b = 0; b < NB; b++) begin mlen[b] = nlen[b]; mwr[b] = wr0[b]; mrd[b] = rd0[b]; end
    end
  end

  task automatic idle();
    cfg_we = 0; cfg_buffer = 0; cfg_len = 0;
    write_valid = 0; write_buffer = 0; write_data = '0;
    read_enable = 0; read_buffer = 0;
    clear_enable = 0; clear_buffer = 0;
`ifdef TILE_BUFFER_ERR_EN
    err_clear = 0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wd_cnt;
    idle();
    reset = 1;
    tick(); tick();
    chk("L_rst_wready", write_ready, 1);
    chk("L_rst_full", buf_full, 0);
    reset = 0;

    // buf1 with 4 tiles, fill it, then one ignored write
    cfg_we = 1; cfg_buffer = 1; cfg_len = 4;
    tick(); idle();
    for (int i = 0; i < 4; i++) begin
      write_valid = 1; write_buffer = 1; write_data = rep(8'(8'hA0 + i));
      tick();
    end
    chk("L_wdone", writing_done, 1);
    chk("L_full1", buf_full[1], 1);
    write_data = rep(8'hA4);
    #1 chk("L_wready_full", write_ready, 0);
    tick();
    chk("L_wdone_once", writing_done, 0);
    idle();

    // six reads wrap through the 4 stored tiles
    read_enable = 1; read_buffer = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("L_rvalid", read_valid, 1);
      chk("L_rdata0", read_data[0], 8'(8'hA0 + (k % 4)));
      chk("L_rdone", reading_done, k == 3);
    end
    idle();

    // streaming: same-cycle write and read sees the pre-write count
    cfg_we = 1; cfg_buffer = 2; cfg_len = 32;
    tick(); idle();
    write_valid = 1; write_buffer = 2; write_data = rep(8'h11);
    read_enable = 1; read_buffer = 2;
    #1 chk("L_stream_rready0", read_ready, 0);
    chk("L_stream_wready", write_ready, 1);
    tick();
    chk("L_stream_norv", read_valid, 0);
    write_valid = 0;
    #1 chk("L_stream_rready1", read_ready, 1);
    tick();
    chk("L_stream_rv", read_valid, 1);
    chk("L_stream_data", rdpk(), rep(8'h11));
    idle();

    // clear and write in the same cycle lands at index 0
    clear_enable = 1; clear_buffer = 2;
    write_valid = 1; write_buffer = 2; write_data = rep(8'h55);
    #1 chk("L_clr_wready", write_ready, 1);
    tick(); idle();
    read_enable = 1; read_buffer = 2;
    #1 chk("L_clr_rready", read_ready, 1);
    tick();
    chk("L_clr_rv", read_valid, 1);
    chk("L_clr_data", rdpk(), rep(8'h55));
    #1 chk("L_clr_empty", read_ready, 0);
    idle();

    // buf0 (len 0) and buf3 (len 63) both mean 32 tiles
    cfg_we = 1; cfg_buffer = 0; cfg_len = 0;
    tick();
    cfg_buffer = 3; cfg_len = 63;
    tick(); idle();
    wd_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      write_valid = 1; write_buffer = 0; write_data = rep(8'(i));
      tick(); wd_cnt += int'(writing_done);
      write_buffer = 3; write_data = rep(8'(8'h80 + i));
      tick(); wd_cnt += int'(writing_done);
      if (i == 9) chk("L_dbg10", debug_w_tile_index, 10);
    end
    idle();
    tick(); wd_cnt += int'(writing_done);
    chk("L_two_done", wd_cnt, 2);
    chk("L_full_map", buf_full, 4'b1011);
    chk("L_dbg_wrap", debug_w_tile_index, 0);
    read_enable = 1; read_buffer = 3;
    tick();
    chk("L_buf3_data", rdpk(), rep(8'h80));

    // reset while a read is in flight
    read_buffer = 0;
    tick();
    chk("L_pre_rst_rv", read_valid, 1);
    chk("L_pre_rst_data", rdpk(), rep(8'h00));
    reset = 1;
    #1 chk("L_rst_rv_drop", read_valid, 0);
    tick();
    chk("L_rst_rv", read_valid, 0);
    chk("L_rst_full0", buf_full, 0);
    chk("L_rst_wready1", write_ready, 1);
    reset = 0;
    idle();
    tick();

`ifdef TILE_BUFFER_ERR_EN
    read_enable = 1; read_buffer = 1;
    tick(); idle();
    chk("L_err_set", err_sticky, 1);
    err_clear = 1;
    tick(); idle();
    chk("L_err_clr", err_sticky, 0);
    read_enable = 1; read_buffer = 1; err_clear = 1;
    tick(); idle();
    chk("L_err_set_wins", err_sticky, 1);
    err_clear = 1;
    tick(); idle();
`endif

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
